// File: rtl/alu_op_sequencer_pkg.sv
// alu_pkg: widths, opcodes and FSM encoding shared by the Mini-ALU op sequencer,
// its bus interface, the optional multiply step and the testbench.
package alu_pkg;

   // Operand/result width. Only 6 is supported.
   localparam int W     = 6;
   localparam int OPC_W = 3;

   localparam logic [OPC_W-1:0] ALU_ADD = 3'b000;
   localparam logic [OPC_W-1:0] ALU_SUB = 3'b001;
   localparam logic [OPC_W-1:0] ALU_NEG = 3'b010;
   localparam logic [OPC_W-1:0] ALU_ABS = 3'b011;
   localparam logic [OPC_W-1:0] ALU_MUL = 3'b100;

   // Most negative operand; NEG/ABS of this value overflow.
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   // Number of shift-add iterations for MUL, one per bit of b.
   localparam logic [2:0] MUL_STEPS = 3'(W);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_NEGB = 3'd1,
      ST_EXEC = 3'd2,
      ST_MUL  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: op request and result handshake bundle of the Mini-ALU sequencer.
// master = the requester / result consumer, slave = the sequencer.
interface alu_op_sequencer_if;
   import alu_pkg::*;

   logic             op_valid;
   logic             op_ready;
   logic [OPC_W-1:0] op_code;
   logic [W-1:0]     op_a;
   logic [W-1:0]     op_b;

   logic             res_valid;
   logic             res_ready;
   logic [W-1:0]     res_data;
   logic             res_ovf;
   logic             res_err;

   modport master (
      output op_valid, op_code, op_a, op_b, res_ready,
      input  op_ready, res_valid, res_data, res_ovf, res_err
   );

   modport slave (
      input  op_valid, op_code, op_a, op_b, res_ready,
      output op_ready, res_valid, res_data, res_ovf, res_err
   );

endinterface

// File: rtl/alu_op_sequencer_mul_step.sv
// alu_mul_step: one shift-add iteration of the unsigned multiply. Produces the
// partial product (a << i when b[i] is set) and flags operand bits shifted past
// the top of the W-bit result. Only built when ALU_SEQ_MUL_EN is defined.
`ifdef ALU_SEQ_MUL_EN
module alu_mul_step
   import alu_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   i,
   output logic [W-1:0] pp,
   output logic         lost
);

   logic [2*W-1:0] wide;
   logic           bit_set;

   // Partial product and shifted-out check for iteration i.
   always_comb begin
      bit_set = (i < MUL_STEPS) ? b[i] : 1'b0;
      wide    = {{W{1'b0}}, a} << i;
      pp      = bit_set ? wide[W-1:0] : '0;
      lost    = bit_set & (|wide[2*W-1:W]);
   end

endmodule
`endif

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle op controller for the Mini-ALU. Accepts one op per
// handshake and steps ADD/SUB/NEG/ABS (and MUL) through the single external 6-bit adder.
// Build option ALU_SEQ_MUL_EN: when defined, opcode 100 runs a 6-step shift-add
// multiply; when undefined, no MUL logic is built and opcode 100 reports res_err.
module alu_op_sequencer
   import alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   alu_op_sequencer_if.slave  bus,
   output logic [W-1:0]       add_x,
   output logic [W-1:0]       add_y,
   input  logic [W-1:0]       add_sum,
   input  logic               add_cout
);

   state_e           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [OPC_W-1:0] opc_q, opc_d;
   logic [W-1:0]     nb_q, nb_d;
   logic [W-1:0]     res_q, res_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;

`ifdef ALU_SEQ_MUL_EN
   logic [W-1:0]     acc_q, acc_d;
   logic [2:0]       i_q, i_d;
   logic [W-1:0]     mul_pp;
   logic             mul_lost;

   alu_mul_step u_mul_step (
      .a    (a_q),
      .b    (b_q),
      .i    (i_q),
      .pp   (mul_pp),
      .lost (mul_lost)
   );
`else
   // The carry is only consumed by the multiply.
   logic             unused_cout;
   assign unused_cout = add_cout;
`endif

   assign bus.op_ready  = (state_q == ST_IDLE);
   assign bus.res_valid = (state_q == ST_DONE);
   assign bus.res_data  = res_q;
   assign bus.res_ovf   = ovf_q;
   assign bus.res_err   = err_q;

   // Next-state, operand capture and adder operand selection.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      opc_d   = opc_q;
      nb_d    = nb_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      add_x   = '0;
      add_y   = '0;
`ifdef ALU_SEQ_MUL_EN
      acc_d   = acc_q;
      i_d     = i_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.op_valid) begin
               a_d   = bus.op_a;
               b_d   = bus.op_b;
               opc_d = bus.op_code;
               ovf_d = 1'b0;
               err_d = 1'b0;
               case (bus.op_code)
                  ALU_ADD, ALU_NEG, ALU_ABS: state_d = ST_EXEC;
                  ALU_SUB:                   state_d = ST_NEGB;
`ifdef ALU_SEQ_MUL_EN
                  ALU_MUL: begin
                     state_d = ST_MUL;
                     acc_d   = '0;
                     i_d     = '0;
                  end
`endif
                  default: begin
                     state_d = ST_DONE;
                     err_d   = 1'b1;
                     res_d   = '0;
                  end
               endcase
            end
         end

         // Two's complement of b for SUB, kept for the EXEC add.
         ST_NEGB: begin
            add_x   = ~b_q;
            add_y   = W'(1);
            nb_d    = add_sum;
            state_d = ST_EXEC;
         end

         ST_EXEC: begin
            case (opc_q)
               ALU_SUB: begin
                  add_x = a_q;
                  add_y = nb_q;
                  ovf_d = (a_q[W-1] != b_q[W-1]) && (add_sum[W-1] != a_q[W-1]);
               end
               ALU_NEG: begin
                  add_x = ~a_q;
                  add_y = W'(1);
                  ovf_d = (a_q == MIN_NEG);
               end
               ALU_ABS: begin
                  add_x = a_q[W-1] ? ~a_q : a_q;
                  add_y = a_q[W-1] ? W'(1) : '0;
                  ovf_d = (a_q == MIN_NEG);
               end
               default: begin
                  add_x = a_q;
                  add_y = b_q;
                  ovf_d = (a_q[W-1] == b_q[W-1]) && (add_sum[W-1] != a_q[W-1]);
               end
            endcase
            res_d   = add_sum;
            state_d = ST_DONE;
         end

`ifdef ALU_SEQ_MUL_EN
         // Six shift-add steps, then one cycle to move the product to the result.
         ST_MUL: begin
            if (i_q == MUL_STEPS) begin
               res_d   = acc_q;
               state_d = ST_DONE;
            end else begin
               add_x = acc_q;
               add_y = mul_pp;
               acc_d = add_sum;
               ovf_d = ovf_q | add_cout | mul_lost;
               i_d   = i_q + 3'd1;
            end
         end
`endif

         ST_DONE: begin
            if (bus.res_ready) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; a reset mid-op drops the op entirely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         opc_q   <= '0;
         nb_q    <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         acc_q   <= '0;
         i_q     <= '0;
`endif
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         opc_q   <= opc_d;
         nb_q    <= nb_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
`ifdef ALU_SEQ_MUL_EN
         acc_q   <= acc_d;
         i_q     <= i_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed stimulus for the Mini-ALU op sequencer with a
// behavioural 6-bit adder. Expected results are queued at issue time and a
// separate monitor compares them (data, ovf, err, latency) when res_valid rises.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   typedef struct {
      logic [W-1:0] data;
      logic         ovf;
      logic         err;
      int           lat;
      int           acc_cyc;
      string        name;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] add_x;
   logic [W-1:0] add_y;
   logic [W-1:0] add_sum;
   logic         add_cout;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t sb_q[$];

   alu_op_sequencer_if bus ();

   alu_op_sequencer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .add_x    (add_x),
      .add_y    (add_y),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   // Behavioural shared adder.
   assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compares each new result against the head of the scoreboard.
   initial begin : monitor
      bit   seen;
      exp_t e;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
         end else begin
            if (bus.res_valid && !seen) begin
               seen = 1'b1;
               if (sb_q.size() == 0) begin
                  check("unexpected_result", 32'(bus.res_data) + 32'd1000, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check({e.name, "_data"}, 32'(bus.res_data), 32'(e.data));
                  check({e.name, "_ovf"},  32'(bus.res_ovf),  32'(e.ovf));
                  check({e.name, "_err"},  32'(bus.res_err),  32'(e.err));
                  check({e.name, "_lat"},  32'(cyc - e.acc_cyc + 1), 32'(e.lat));
               end
            end
            if (bus.res_valid && bus.res_ready) seen = 1'b0;
         end
      end
   end

   // All driver tasks start and end just after a rising edge.
   task automatic wait_ready();
      int n = 0;
      while (!bus.op_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.op_ready) check("op_ready_timeout", 32'(bus.op_ready), 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb_q.size() != 0 || !bus.op_ready) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic issue(input logic [OPC_W-1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] d, input logic ovf, input logic err,
                        input int lat, input string name);
      exp_t e;
      wait_ready();
      bus.op_valid = 1'b1;
      bus.op_code  = opc;
      bus.op_a     = a;
      bus.op_b     = b;
      e.data    = d;
      e.ovf     = ovf;
      e.err     = err;
      e.lat     = lat;
      e.acc_cyc = cyc + 1;
      e.name    = name;
      sb_q.push_back(e);
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_op_ready"},  32'(bus.op_ready),  32'd1);
      check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
      check({tag, "_res_data"},  32'(bus.res_data),  32'd0);
      check({tag, "_res_ovf"},   32'(bus.res_ovf),   32'd0);
      check({tag, "_res_err"},   32'(bus.res_err),   32'd0);
      check({tag, "_add_x"},     32'(add_x),         32'd0);
      check({tag, "_add_y"},     32'(add_y),         32'd0);
   endtask

   initial begin : driver
      int n;
      rst_n         = 1'b0;
      bus.op_valid  = 1'b0;
      bus.op_code   = '0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ADD / SUB
      issue(ALU_ADD, 6'd5,  6'd7, 6'd12, 1'b0, 1'b0, 2, "add_5_7");
      issue(ALU_ADD, 6'd31, 6'd1, 6'd32, 1'b1, 1'b0, 2, "add_31_1");
      issue(ALU_SUB, 6'd3,  6'd5, 6'd62, 1'b0, 1'b0, 3, "sub_3_5");
      issue(ALU_SUB, 6'd32, 6'd1, 6'd31, 1'b1, 1'b0, 3, "sub_32_1");

      // NEG / ABS, including the most negative operand
      issue(ALU_NEG, 6'd1,  6'd0, 6'd63, 1'b0, 1'b0, 2, "neg_1");
      issue(ALU_ABS, 6'd62, 6'd0, 6'd2,  1'b0, 1'b0, 2, "abs_62");
      issue(ALU_ABS, 6'd5,  6'd0, 6'd5,  1'b0, 1'b0, 2, "abs_5");
      issue(ALU_NEG, 6'd32, 6'd0, 6'd32, 1'b1, 1'b0, 2, "neg_32");
      issue(ALU_ABS, 6'd32, 6'd0, 6'd32, 1'b1, 1'b0, 2, "abs_32");

      // MUL, or illegal when compiled out
`ifdef ALU_SEQ_MUL_EN
      issue(ALU_MUL, 6'd7, 6'd9, 6'd63, 1'b0, 1'b0, 8, "mul_7_9");
      issue(ALU_MUL, 6'd8, 6'd8, 6'd0,  1'b1, 1'b0, 8, "mul_8_8");
`else
      issue(ALU_MUL, 6'd7, 6'd9, 6'd0,  1'b0, 1'b1, 1, "mul_disabled");
`endif

      // Backpressure: result held, op_ready low, stray request ignored
      wait_idle();
      bus.res_ready = 1'b0;
      issue(ALU_ADD, 6'd10, 6'd3, 6'd13, 1'b0, 1'b0, 2, "bp_add");
      n = 0;
      while (!bus.res_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_valid_seen", 32'(bus.res_valid), 32'd1);
      bus.op_valid = 1'b1;
      bus.op_code  = ALU_ADD;
      bus.op_a     = 6'd1;
      bus.op_b     = 6'd1;
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_hold_valid",    32'(bus.res_valid), 32'd1);
         check("bp_hold_data",     32'(bus.res_data),  32'd13);
         check("bp_hold_op_ready", 32'(bus.op_ready),  32'd0);
      end
      bus.op_valid  = 1'b0;
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_popped_idle", 32'(bus.op_ready), 32'd1);
      repeat (3) begin
         @(posedge clk); #1;
         check("bp_stray_not_taken", 32'(bus.res_valid), 32'd0);
      end

      // Reset during MUL cycle 3 drops the op
      wait_idle();
`ifdef ALU_SEQ_MUL_EN
      issue(ALU_MUL, 6'd7, 6'd9, 6'd63, 1'b0, 1'b0, 8, "rst_mul");
`else
      issue(ALU_MUL, 6'd7, 6'd9, 6'd0,  1'b0, 1'b1, 1, "rst_mul");
`endif
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check_reset_outputs("midop_reset");
      repeat (2) @(posedge clk);
      #1;
      check("midop_reset_no_result", 32'(bus.res_valid), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(ALU_ADD, 6'd1, 6'd1, 6'd2, 1'b0, 1'b0, 2, "post_rst_add");
      issue(3'b111,  6'd9, 6'd4, 6'd0, 1'b0, 1'b1, 1, "illegal_111");

      wait_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
